mem_stage: RTL

Pipeline MEM stage of the five-stage MIPS core: takes the EXE/MEM register contents, performs loads/stores over a req/ack data-memory bus with byte-lane alignment, and registers the MEM/WB results that drive the register-file write port. It is the producer side of the ID-stage forwarding path, sourcing `Aluout_mem`, `Rdata_mem`, `rd_mem`, `RegWrite_mem` and `MemRead_mem`. It raises `keep_mem` to freeze IF/ID/EXE while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_align.sv | 56 +++++
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM pipeline stage.
package mem_pkg;

   typedef enum logic [1:0] {
      MR_NONE = 2'b00,
      MR_LW   = 2'b01,
      MR_LB   = 2'b10,
      MR_LBU  = 2'b11
   } mem_read_e;

   typedef enum logic [1:0] {
      MW_NONE = 2'b00,
      MW_SW   = 2'b01,
      MW_SB   = 2'b10,
      MW_SH   = 2'b11
   } mem_write_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   localparam int ACK_TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, load extraction/extension, misalignment detect.
module mem_align
   import mem_pkg::*;
(
   input  mem_write_e  st_op,
   input  mem_read_e   chk_ld_op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  mem_read_e   ld_op,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_fmt,
   output logic        misalign
);

   logic [7:0] ld_byte;

   // store lanes: sub-word data is replicated so the enabled lane always carries it
   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (st_op)
         MW_SB: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         MW_SH: begin
            be         = 4'b0011 << addr_lo;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // word accesses need both low bits clear, halfword stores need bit 0 clear
   always_comb begin
      misalign = 1'b0;
      if ((st_op == MW_SW || chk_ld_op == MR_LW) && addr_lo != 2'b00)
         misalign = 1'b1;
      if (st_op == MW_SH && addr_lo[0])
         misalign = 1'b1;
   end

   // little-endian byte pick followed by sign or zero extension
   always_comb begin
      ld_byte = 8'(rdata >> {ld_off, 3'b000});
      case (ld_op)
         MR_LB:   rdata_fmt = {{24{ld_byte[7]}}, ld_byte};
         MR_LBU:  rdata_fmt = {24'h0, ld_byte};
         default: rdata_fmt = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory bus sequencing and the MEM/WB register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access outstanding; non-memory ops pass straight to MEM/WB
// ST_WAIT | request on the bus, waiting for mem_ack or the ack timeout
module mem_stage
   import mem_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] Aluout_in,
   input  logic [31:0] wdata_in,
   input  logic [4:0]  rd_in,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic [1:0]  MemRead_in,
   input  logic [1:0]  MemWrite_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] Aluout_mem,
   output logic [31:0] Rdata_mem,
   output logic [4:0]  rd_mem,
   output logic        RegWrite_mem,
   output logic [1:0]  MemRead_mem,
   output logic        keep_mem,
   output logic [4:0]  rd_wb,
   output logic        RegWrite_wb,
   output logic [31:0] data_wb,
   output logic        exc_misalign,
   output logic        bus_err
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   mem_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d, we_q, we_d;
   logic [31:0]   addr_q, addr_d, wdat_q, wdat_d;
   logic [3:0]    be_q, be_d;
   mem_read_e     ld_op_q, ld_op_d;
   logic [31:0]   ld_alu_q, ld_alu_d;
   logic [4:0]    ld_rd_q, ld_rd_d, rd_wb_q, rd_wb_d;
   logic          ld_rw_q, ld_rw_d, ld_m2r_q, ld_m2r_d;
   logic          rw_wb_q, rw_wb_d, exc_q, exc_d, berr_q, berr_d;
   logic [31:0]   data_wb_q, data_wb_d;

   mem_read_e     rd_op;
   mem_write_e    wr_op;
   logic          is_mem_op, is_store, misalign, issue, tc_hit, ack_done;
   logic [3:0]    be_lane;
   logic [31:0]   wdata_lane, rdata_fmt;

   assign rd_op     = mem_read_e'(MemRead_in);
   assign wr_op     = mem_write_e'(MemWrite_in);
   assign is_mem_op = (rd_op != MR_NONE) || (wr_op != MW_NONE);
   assign is_store  = (wr_op != MW_NONE) && (rd_op == MR_NONE);
   assign issue     = (state_q == ST_IDLE) && valid_in && is_mem_op && !misalign;
   assign tc_hit    = (state_q == ST_WAIT) && (cnt_q == '0);
   assign ack_done  = (state_q == ST_WAIT) && mem_ack;

   mem_align u_align (
      .st_op      (is_store ? wr_op : MW_NONE),
      .chk_ld_op  (rd_op),
      .addr_lo    (Aluout_in[1:0]),
      .wdata      (wdata_in),
      .ld_op      (ld_op_q),
      .ld_off     (ld_alu_q[1:0]),
      .rdata      (mem_rdata),
      .be         (be_lane),
      .wdata_lane (wdata_lane),
      .rdata_fmt  (rdata_fmt),
      .misalign   (misalign)
   );

   assign keep_mem     = issue || ((state_q == ST_WAIT) && !mem_ack && !tc_hit);
   assign Aluout_mem   = Aluout_in;
   assign rd_mem       = rd_in;
   assign MemRead_mem  = MemRead_in;
   assign RegWrite_mem = RegWrite_in & valid_in;
   assign Rdata_mem    = ack_done ? rdata_fmt : 32'h0;

   assign mem_req      = req_q;
   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdat_q;
   assign mem_be       = be_q;
   assign rd_wb        = rd_wb_q;
   assign RegWrite_wb  = rw_wb_q;
   assign data_wb      = data_wb_q;
   assign exc_misalign = exc_q;
   assign bus_err      = berr_q;

   // next-state, bus and MEM/WB logic; MEM/WB defaults to a bubble
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      be_d      = be_q;
      ld_op_d   = ld_op_q;
      ld_alu_d  = ld_alu_q;
      ld_rd_d   = ld_rd_q;
      ld_rw_d   = ld_rw_q;
      ld_m2r_d  = ld_m2r_q;
      rd_wb_d   = 5'd0;
      rw_wb_d   = 1'b0;
      data_wb_d = 32'h0;
      exc_d     = 1'b0;
      berr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid_in && is_mem_op) begin
               if (misalign) begin
                  exc_d = 1'b1;
               end else begin
                  req_d    = 1'b1;
                  we_d     = is_store;
                  addr_d   = {Aluout_in[31:2], 2'b00};
                  wdat_d   = wdata_lane;
                  be_d     = be_lane;
                  ld_op_d  = is_store ? MR_NONE : rd_op;
                  ld_alu_d = Aluout_in;
                  ld_rd_d  = rd_in;
                  ld_rw_d  = RegWrite_in;
                  ld_m2r_d = MemtoReg_in;
                  cnt_d    = CW'(ACK_TIMEOUT);
                  state_d  = ST_WAIT;
               end
            end else begin
               rd_wb_d   = rd_in;
               rw_wb_d   = RegWrite_in & valid_in;
               data_wb_d = Aluout_in;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = ST_IDLE;
               if (ld_op_q != MR_NONE) begin
                  rd_wb_d   = ld_rd_q;
                  rw_wb_d   = ld_rw_q;
                  data_wb_d = ld_m2r_q ? rdata_fmt : ld_alu_q;
               end
            end else if (tc_hit) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               berr_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, bus and MEM/WB registers; reset abandons any outstanding access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         wdat_q    <= 32'h0;
         be_q      <= 4'h0;
         ld_op_q   <= MR_NONE;
         ld_alu_q  <= 32'h0;
         ld_rd_q   <= 5'd0;
         ld_rw_q   <= 1'b0;
         ld_m2r_q  <= 1'b0;
         rd_wb_q   <= 5'd0;
         rw_wb_q   <= 1'b0;
         data_wb_q <= 32'h0;
         exc_q     <= 1'b0;
         berr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         be_q      <= be_d;
         ld_op_q   <= ld_op_d;
         ld_alu_q  <= ld_alu_d;
         ld_rd_q   <= ld_rd_d;
         ld_rw_q   <= ld_rw_d;
         ld_m2r_q  <= ld_m2r_d;
         rd_wb_q   <= rd_wb_d;
         rw_wb_q   <= rw_wb_d;
         data_wb_q <= data_wb_d;
         exc_q     <= exc_d;
         berr_q    <= berr_d;
      end
   end

endmodule
